// File: rtl/usr_pkg.sv
// usr_pkg: shared opcode, mode and state definitions for the shift-register sequencer.
package usr_pkg;
    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_SHR = 2'd1;
    localparam logic [1:0] OP_SHL = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR = 2'b01;
    localparam logic [1:0] MODE_SHL = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;
    typedef enum logic {IDLE, EXEC} state_e;
    function automatic logic is_shift_op(input logic [1:0] op);
        return op == OP_SHR || op == OP_SHL;
    endfunction
endpackage

// File: rtl/usr_seq_ctrl_if.sv
// usr_seq_ctrl_if: command, serial-in and serial-out handshakes of the sequencer.
interface usr_seq_ctrl_if #(parameter int WIDTH = 4, parameter int CNT_W = 4);
    logic cmd_valid;
    logic cmd_ready;
    logic [1:0] cmd_op;
    logic [CNT_W-1:0] cmd_len;
    logic [WIDTH-1:0] cmd_data;
    logic sin_valid;
    logic sin_data;
    logic sin_ready;
    logic sout_valid;
    logic sout_data;
    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data, sin_valid, sin_data,
        input cmd_ready, sin_ready, sout_valid, sout_data
    );
    modport slave (
        input cmd_valid, cmd_op, cmd_len, cmd_data, sin_valid, sin_data,
        output cmd_ready, sin_ready, sout_valid, sout_data
    );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal_shift_reg: 4-mode shift register (hold/shift-right/shift-left/load) driven by the sequencer.
module Universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             s1_i,
    input  logic             s0_i,
    input  logic [WIDTH-1:0] par_i,
    input  logic             msb_in_i,
    input  logic             lsb_in_i,
    output logic [WIDTH-1:0] q_o,
    output logic             msb_out_o,
    output logic             lsb_out_o
);
    logic [WIDTH-1:0] q_q, q_d;
    always_comb begin
        q_d = {s1_i, s0_i} == MODE_LOAD ? par_i :
              {s1_i, s0_i} == MODE_SHR ? {msb_in_i, q_q[WIDTH-1:1]} :
              {s1_i, s0_i} == MODE_SHL ? {q_q[WIDTH-2:0], lsb_in_i} : q_q;
    end
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end
    assign q_o = q_q;
    assign msb_out_o = q_q[WIDTH-1];
    assign lsb_out_o = q_q[0];
endmodule

// File: rtl/usr_seq_ctrl_shift_len_counter.sv
// shift_len_counter: loadable down-counter of remaining shifts with zero/one flags.
module shift_len_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             one_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = load_i ? load_val_i : (dec_i && !zero_o) ? cnt_q - CNT_W'(1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end
    assign zero_o = cnt_q == '0;
    assign one_o = cnt_q == CNT_W'(1);
endmodule

// File: rtl/usr_seq_ctrl.sv
// usr_seq_ctrl: sequences load/clear/N-shift commands onto an adjacent universal shift register.
module usr_seq_ctrl
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    usr_seq_ctrl_if.slave    bus,
    output logic             sr_s1,
    output logic             sr_s0,
    output logic [WIDTH-1:0] sr_data_in,
    output logic             sr_msb_in,
    output logic             sr_lsb_in,
    input  logic             sr_msb_out,
    input  logic             sr_lsb_out,
    output logic             busy,
    output logic             done
);
    state_e state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic done_q, done_d;
    logic accept, exec, is_shift, shr, shift, fin, zero_len, cnt_zero, cnt_one;
    logic [1:0] mode;
    shift_len_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk(clk),
        .rst(rst),
        .load_i(accept),
        .load_val_i(bus.cmd_len),
        .dec_i(shift),
        .zero_o(cnt_zero),
        .one_o(cnt_one)
    );
    // Outputs are gated by rst so the register sees hold while reset is asserted.
    always_comb begin
        exec = state_q == EXEC && !rst;
        is_shift = is_shift_op(op_q);
        shr = op_q == OP_SHR;
        shift = exec && is_shift && bus.sin_valid;
        accept = bus.cmd_valid && state_q == IDLE && !rst;
        zero_len = is_shift_op(bus.cmd_op) && bus.cmd_len == '0;
        fin = exec && (!is_shift || (shift && cnt_one) || cnt_zero);
        op_d = accept ? bus.cmd_op : op_q;
        data_d = accept ? bus.cmd_data : data_q;
        state_d = accept ? (zero_len ? IDLE : EXEC) : fin ? IDLE : state_q;
        done_d = accept ? zero_len : fin;
        mode = !exec ? MODE_HOLD : !is_shift ? MODE_LOAD : !bus.sin_valid ? MODE_HOLD :
               shr ? MODE_SHR : MODE_SHL;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            data_q <= data_d;
            done_q <= done_d;
        end
    end
    assign bus.cmd_ready = state_q == IDLE && !rst;
    assign bus.sin_ready = shift;
    assign bus.sout_valid = shift;
    assign bus.sout_data = shift && (shr ? sr_lsb_out : sr_msb_out);
    assign {sr_s1, sr_s0} = mode;
    assign sr_data_in = (exec && op_q == OP_LOAD) ? data_q : '0;
    assign sr_msb_in = shift && shr && bus.sin_data;
    assign sr_lsb_in = shift && !shr && bus.sin_data;
    assign busy = state_q == EXEC;
    assign done = done_q;
endmodule

// File: tb/tb_usr_seq_ctrl.sv
// tb_usr_seq_ctrl: directed scenarios for the sequencer driving a real universal shift register.
module tb_usr_seq_ctrl;
    import usr_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sr_s1, sr_s0, sr_msb_in, sr_lsb_in, sr_msb_out, sr_lsb_out, busy, done;
    logic [3:0] sr_data_in, sr_q;
    int n_chk = 0;
    int n_err = 0;
    usr_seq_ctrl_if #(.WIDTH(4), .CNT_W(4)) bus ();
    usr_seq_ctrl #(.WIDTH(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .sr_s1(sr_s1), .sr_s0(sr_s0), .sr_data_in(sr_data_in),
        .sr_msb_in(sr_msb_in), .sr_lsb_in(sr_lsb_in),
        .sr_msb_out(sr_msb_out), .sr_lsb_out(sr_lsb_out),
        .busy(busy), .done(done)
    );
    Universal_shift_reg #(.WIDTH(4)) u_sr (
        .clk(clk), .s1_i(sr_s1), .s0_i(sr_s0), .par_i(sr_data_in),
        .msb_in_i(sr_msb_in), .lsb_in_i(sr_lsb_in),
        .q_o(sr_q), .msb_out_o(sr_msb_out), .lsb_out_o(sr_lsb_out)
    );
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cmd(input logic [1:0] op, input logic [3:0] len, input logic [3:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_len = len;
        bus.cmd_data = data;
    endtask

    task automatic test_reset;
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_len = 0; bus.cmd_data = 0;
        bus.sin_valid = 0; bus.sin_data = 0;
        rst = 1'b1;
        step;
        step;
        n_chk++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_cmd_ready: got %b exp 0", bus.cmd_ready); end
        n_chk++; if (bus.sin_ready !== 1'b0) begin n_err++; $display("FAIL reset_sin_ready: got %b exp 0", bus.sin_ready); end
        n_chk++; if (bus.sout_valid !== 1'b0) begin n_err++; $display("FAIL reset_sout_valid: got %b exp 0", bus.sout_valid); end
        n_chk++; if ({sr_s1, sr_s0} !== 2'b00) begin n_err++; $display("FAIL reset_mode: got %b exp 00", {sr_s1, sr_s0}); end
        n_chk++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_done_busy: got %b%b exp 00", done, busy); end
        rst = 1'b0;
        step;
        n_chk++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL idle_cmd_ready: got %b exp 1", bus.cmd_ready); end
    endtask

    task automatic test_load;
        cmd(OP_LOAD, 4'd0, 4'b1010);
        #1;
        step;
        bus.cmd_valid = 1'b0;
        #1;
        n_chk++; if ({sr_s1, sr_s0} !== 2'b11) begin n_err++; $display("FAIL load_mode: got %b exp 11", {sr_s1, sr_s0}); end
        n_chk++; if (sr_data_in !== 4'b1010) begin n_err++; $display("FAIL load_data_in: got %b exp 1010", sr_data_in); end
        n_chk++; if (busy !== 1'b1 || bus.cmd_ready !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL load_exec_flags: got busy=%b rdy=%b done=%b exp 1 0 0", busy, bus.cmd_ready, done); end
        step;
        n_chk++; if (sr_q !== 4'b1010) begin n_err++; $display("FAIL load_reg: got %b exp 1010", sr_q); end
        n_chk++; if (done !== 1'b1 || bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL load_done: got done=%b rdy=%b exp 1 1", done, bus.cmd_ready); end
        n_chk++; if ({sr_s1, sr_s0} !== 2'b00 || sr_data_in !== 4'b0000) begin n_err++; $display("FAIL load_idle_pins: got mode=%b data=%b exp 00 0000", {sr_s1, sr_s0}, sr_data_in); end
        step;
        n_chk++; if (done !== 1'b0) begin n_err++; $display("FAIL load_done_pulse: got %b exp 0", done); end
    endtask

    task automatic test_shr;
        logic [1:0] exp_sout = 2'b10;
        cmd(OP_SHR, 4'd2, 4'b0000);
        bus.sin_valid = 1'b1;
        bus.sin_data = 1'b1;
        #1;
        n_chk++; if (bus.sin_ready !== 1'b0) begin n_err++; $display("FAIL shr_idle_sin_ready: got %b exp 0", bus.sin_ready); end
        step;
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_chk++; if ({sr_s1, sr_s0} !== 2'b01 || bus.sin_ready !== 1'b1 || bus.sout_valid !== 1'b1) begin n_err++; $display("FAIL shr_mode_%0d: got mode=%b sin_rdy=%b sout_v=%b exp 01 1 1", i, {sr_s1, sr_s0}, bus.sin_ready, bus.sout_valid); end
            n_chk++; if (bus.sout_data !== exp_sout[i]) begin n_err++; $display("FAIL shr_sout_%0d: got %b exp %b", i, bus.sout_data, exp_sout[i]); end
            n_chk++; if (sr_msb_in !== 1'b1 || sr_lsb_in !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL shr_pins_%0d: got msb=%b lsb=%b done=%b exp 1 0 0", i, sr_msb_in, sr_lsb_in, done); end
            step;
        end
        n_chk++; if (sr_q !== 4'b1110) begin n_err++; $display("FAIL shr_reg: got %b exp 1110", sr_q); end
        n_chk++; if (done !== 1'b1 || busy !== 1'b0 || bus.sin_ready !== 1'b0 || bus.sout_valid !== 1'b0) begin n_err++; $display("FAIL shr_done: got done=%b busy=%b sin_rdy=%b sout_v=%b exp 1 0 0 0", done, busy, bus.sin_ready, bus.sout_valid); end
        bus.sin_valid = 1'b0;
        step;
    endtask

    task automatic test_shl;
        logic [2:0] bits = 3'b010;
        cmd(OP_SHL, 4'd3, 4'b0000);
        bus.sin_valid = 1'b1;
        step;
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.sin_data = bits[i];
            #1;
            n_chk++; if ({sr_s1, sr_s0} !== 2'b10 || bus.sout_data !== 1'b1) begin n_err++; $display("FAIL shl_step_%0d: got mode=%b sout=%b exp 10 1", i, {sr_s1, sr_s0}, bus.sout_data); end
            n_chk++; if (sr_lsb_in !== bits[i] || sr_msb_in !== 1'b0) begin n_err++; $display("FAIL shl_serial_%0d: got lsb=%b msb=%b exp %b 0", i, sr_lsb_in, sr_msb_in, bits[i]); end
            step;
        end
        n_chk++; if (sr_q !== 4'b0010 || done !== 1'b1) begin n_err++; $display("FAIL shl_end: got reg=%b done=%b exp 0010 1", sr_q, done); end
        bus.sin_valid = 1'b0;
        step;
    endtask

    task automatic test_stall;
        cmd(OP_SHR, 4'd2, 4'b0000);
        bus.sin_valid = 1'b1;
        bus.sin_data = 1'b1;
        step;
        bus.cmd_valid = 1'b0;
        #1;
        n_chk++; if ({sr_s1, sr_s0} !== 2'b01 || bus.sout_data !== 1'b0) begin n_err++; $display("FAIL stall_first: got mode=%b sout=%b exp 01 0", {sr_s1, sr_s0}, bus.sout_data); end
        step;
        bus.sin_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if ({sr_s1, sr_s0} !== 2'b00 || bus.sin_ready !== 1'b0 || bus.sout_valid !== 1'b0) begin n_err++; $display("FAIL stall_hold_%0d: got mode=%b sin_rdy=%b sout_v=%b exp 00 0 0", i, {sr_s1, sr_s0}, bus.sin_ready, bus.sout_valid); end
            n_chk++; if (done !== 1'b0 || busy !== 1'b1 || dut.u_cnt.cnt_q !== 4'd1 || sr_q !== 4'b1001) begin n_err++; $display("FAIL stall_state_%0d: got done=%b busy=%b cnt=%0d reg=%b exp 0 1 1 1001", i, done, busy, dut.u_cnt.cnt_q, sr_q); end
            step;
        end
        bus.sin_valid = 1'b1;
        bus.sin_data = 1'b0;
        #1;
        n_chk++; if ({sr_s1, sr_s0} !== 2'b01 || bus.sout_data !== 1'b1) begin n_err++; $display("FAIL stall_second: got mode=%b sout=%b exp 01 1", {sr_s1, sr_s0}, bus.sout_data); end
        step;
        n_chk++; if (sr_q !== 4'b0100 || done !== 1'b1) begin n_err++; $display("FAIL stall_end: got reg=%b done=%b exp 0100 1", sr_q, done); end
        bus.sin_valid = 1'b0;
        step;
    endtask

    task automatic test_zero_len;
        cmd(OP_SHL, 4'd0, 4'b1111);
        bus.sin_valid = 1'b1;
        bus.sin_data = 1'b1;
        #1;
        n_chk++; if (bus.sin_ready !== 1'b0) begin n_err++; $display("FAIL zlen_accept_sin_ready: got %b exp 0", bus.sin_ready); end
        step;
        bus.cmd_valid = 1'b0;
        #1;
        n_chk++; if (done !== 1'b1 || busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL zlen_done: got done=%b busy=%b rdy=%b exp 1 0 1", done, busy, bus.cmd_ready); end
        n_chk++; if (bus.sin_ready !== 1'b0 || {sr_s1, sr_s0} !== 2'b00) begin n_err++; $display("FAIL zlen_pins: got sin_rdy=%b mode=%b exp 0 00", bus.sin_ready, {sr_s1, sr_s0}); end
        step;
        n_chk++; if (done !== 1'b0 || sr_q !== 4'b0100 || bus.sin_ready !== 1'b0) begin n_err++; $display("FAIL zlen_after: got done=%b reg=%b sin_rdy=%b exp 0 0100 0", done, sr_q, bus.sin_ready); end
        bus.sin_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        cmd(OP_LOAD, 4'd0, 4'b0110);
        step;
        bus.cmd_data = 4'b1011;
        #1;
        n_chk++; if (bus.cmd_ready !== 1'b0 || sr_data_in !== 4'b0110) begin n_err++; $display("FAIL b2b_first_exec: got rdy=%b data=%b exp 0 0110", bus.cmd_ready, sr_data_in); end
        step;
        n_chk++; if (done !== 1'b1 || bus.cmd_ready !== 1'b1 || sr_q !== 4'b0110) begin n_err++; $display("FAIL b2b_first_done: got done=%b rdy=%b reg=%b exp 1 1 0110", done, bus.cmd_ready, sr_q); end
        step;
        bus.cmd_valid = 1'b0;
        #1;
        n_chk++; if ({sr_s1, sr_s0} !== 2'b11 || sr_data_in !== 4'b1011 || done !== 1'b0) begin n_err++; $display("FAIL b2b_second_exec: got mode=%b data=%b done=%b exp 11 1011 0", {sr_s1, sr_s0}, sr_data_in, done); end
        step;
        n_chk++; if (sr_q !== 4'b1011 || done !== 1'b1) begin n_err++; $display("FAIL b2b_second_done: got reg=%b done=%b exp 1011 1", sr_q, done); end
        step;
    endtask

    task automatic test_reset_abort;
        cmd(OP_SHR, 4'd4, 4'b0000);
        bus.sin_valid = 1'b1;
        bus.sin_data = 1'b1;
        step;
        bus.cmd_valid = 1'b0;
        step;
        step;
        n_chk++; if (sr_q !== 4'b1110 || busy !== 1'b1) begin n_err++; $display("FAIL abort_pre: got reg=%b busy=%b exp 1110 1", sr_q, busy); end
        rst = 1'b1;
        #1;
        n_chk++; if ({sr_s1, sr_s0} !== 2'b00 || bus.sin_ready !== 1'b0 || bus.sout_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL abort_in_rst: got mode=%b sin_rdy=%b sout_v=%b rdy=%b exp 00 0 0 0", {sr_s1, sr_s0}, bus.sin_ready, bus.sout_valid, bus.cmd_ready); end
        step;
        n_chk++; if (busy !== 1'b0 || done !== 1'b0 || sr_q !== 4'b1110) begin n_err++; $display("FAIL abort_after: got busy=%b done=%b reg=%b exp 0 0 1110", busy, done, sr_q); end
        rst = 1'b0;
        bus.sin_valid = 1'b0;
        step;
        n_chk++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got done=%b busy=%b exp 0 0", done, busy); end
        cmd(OP_CLEAR, 4'd0, 4'b1111);
        step;
        bus.cmd_valid = 1'b0;
        #1;
        n_chk++; if ({sr_s1, sr_s0} !== 2'b11 || sr_data_in !== 4'b0000) begin n_err++; $display("FAIL clear_exec: got mode=%b data=%b exp 11 0000", {sr_s1, sr_s0}, sr_data_in); end
        step;
        n_chk++; if (sr_q !== 4'b0000 || done !== 1'b1) begin n_err++; $display("FAIL clear_done: got reg=%b done=%b exp 0000 1", sr_q, done); end
        step;
    endtask

    initial begin
        test_reset;
        test_load;
        test_shr;
        test_shl;
        test_stall;
        test_zero_len;
        test_back_to_back;
        test_reset_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
